// File: rtl/fifo_sync_ctrl.sv
// Single-clock pointer/flag controller for the dual-port fifo_mem RAM.
// Produces qualified RAM enables/addresses, occupancy flags, read-valid timing and sticky errors.
module fifo_sync_ctrl #(
    parameter int unsigned ADDR_SIZE       = 4,
    parameter int unsigned ALMOST_FULL_TH  = 14,
    parameter int unsigned ALMOST_EMPTY_TH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_req,
    input  logic                 rd_req,
    input  logic                 err_clr,
    output logic                 wr_en,
    output logic                 rd_en,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [ADDR_SIZE-1:0] rd_addr,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   fifo_cnt,
    output logic                 rd_valid,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int unsigned PTR_W = ADDR_SIZE + 1;
    localparam int unsigned DEPTH = 1 << ADDR_SIZE;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    // Accept decisions come from the registered flags of the current cycle.
    assign wr_en = wr_req & ~full_q;
    assign rd_en = rd_req & ~empty_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        full_d      = full_q;
        empty_d     = empty_q;
        afull_d     = afull_q;
        aempty_d    = aempty_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        cnt_d    = cnt_q + PTR_W'(wr_en) - PTR_W'(rd_en);
        full_d   = (cnt_d == PTR_W'(DEPTH));
        empty_d  = (cnt_d == '0);
        afull_d  = (cnt_d >= PTR_W'(ALMOST_FULL_TH));
        aempty_d = (cnt_d <= PTR_W'(ALMOST_EMPTY_TH));

        rd_valid_d = rd_en;

        // A same-cycle set condition beats err_clr.
        overflow_d  = (wr_req & full_q)  | (overflow_q  & ~err_clr);
        underflow_d = (rd_req & empty_q) | (underflow_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign wr_addr      = wr_ptr_q[ADDR_SIZE-1:0];
    assign rd_addr      = rd_ptr_q[ADDR_SIZE-1:0];
    assign fifo_full    = full_q;
    assign fifo_empty   = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign fifo_cnt     = cnt_q;
    assign rd_valid     = rd_valid_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Self-checking bench for fifo_sync_ctrl: a behavioural RAM plus a data scoreboard
// and a reference occupancy/flag model checked every cycle.
module tb_fifo_sync_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_req, rd_req, err_clr;
    logic       wr_en, rd_en;
    logic [3:0] wr_addr, rd_addr;
    logic       fifo_full, fifo_empty, almost_full, almost_empty;
    logic [4:0] fifo_cnt;
    logic       rd_valid, overflow, underflow;

    logic [7:0] wr_data;
    logic [7:0] ram_rd_data;
    logic [7:0] mem [16];

    logic [7:0] sb_q [$];
    logic [7:0] next_data;
    int         m_cnt;
    logic       m_ovf, m_udf, m_rv;
    logic [4:0] m_wptr, m_rptr;
    int         n_chk  = 0;
    int         n_pass = 0;

    fifo_sync_ctrl #(
        .ADDR_SIZE      (4),
        .ALMOST_FULL_TH (14),
        .ALMOST_EMPTY_TH(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_req      (wr_req),
        .rd_req      (rd_req),
        .err_clr     (err_clr),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .fifo_cnt    (fifo_cnt),
        .rd_valid    (rd_valid),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for fifo_mem with both clocks tied together.
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) ram_rd_data <= mem[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_rv   = 1'b0;
        m_wptr = '0;
        m_rptr = '0;
        sb_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cnt"},    32'(fifo_cnt), 32'd0);
        check({tag, "_empty"},  32'(fifo_empty), 32'd1);
        check({tag, "_aempty"}, 32'(almost_empty), 32'd1);
        check({tag, "_full"},   32'(fifo_full), 32'd0);
        check({tag, "_afull"},  32'(almost_full), 32'd0);
        check({tag, "_rv"},     32'(rd_valid), 32'd0);
        check({tag, "_ovf"},    32'(overflow), 32'd0);
        check({tag, "_udf"},    32'(underflow), 32'd0);
        check({tag, "_waddr"},  32'(wr_addr), 32'd0);
        check({tag, "_raddr"},  32'(rd_addr), 32'd0);
    endtask

    // One clock of stimulus; checks enables before the edge and all state after it.
    task automatic step(input logic w, input logic r, input logic c);
        logic exp_wen, exp_ren;
        logic [7:0] exp_d;
        @(negedge clk);
        wr_req  = w;
        rd_req  = r;
        err_clr = c;
        wr_data = next_data;
        #1;
        exp_wen = w && (m_cnt != 16);
        exp_ren = r && (m_cnt != 0);
        check("wr_en", 32'(wr_en), 32'(exp_wen));
        check("rd_en", 32'(rd_en), 32'(exp_ren));
        if (exp_wen) begin
            sb_q.push_back(next_data);
            next_data = next_data + 8'd1;
        end
        m_ovf = (w && m_cnt == 16) || (m_ovf && !c);
        m_udf = (r && m_cnt == 0)  || (m_udf && !c);
        m_cnt = m_cnt + int'(exp_wen) - int'(exp_ren);
        if (exp_wen) m_wptr = m_wptr + 5'd1;
        if (exp_ren) m_rptr = m_rptr + 5'd1;
        m_rv = exp_ren;
        @(posedge clk);
        #1;
        check("fifo_cnt",     32'(fifo_cnt), 32'(m_cnt));
        check("fifo_full",    32'(fifo_full), 32'(m_cnt == 16));
        check("fifo_empty",   32'(fifo_empty), 32'(m_cnt == 0));
        check("almost_full",  32'(almost_full), 32'(m_cnt >= 14));
        check("almost_empty", 32'(almost_empty), 32'(m_cnt <= 2));
        check("overflow",     32'(overflow), 32'(m_ovf));
        check("underflow",    32'(underflow), 32'(m_udf));
        check("wr_addr",      32'(wr_addr), 32'(m_wptr[3:0]));
        check("rd_addr",      32'(rd_addr), 32'(m_rptr[3:0]));
        check("rd_valid",     32'(rd_valid), 32'(m_rv));
        if (rd_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_underrun", 32'd1, 32'd0);
            end else begin
                exp_d = sb_q.pop_front();
                check("rd_data", 32'(ram_rd_data), 32'(exp_d));
            end
        end
    endtask

    task automatic steps(input int n, input logic w, input logic r, input logic c);
        for (int i = 0; i < n; i++) step(w, r, c);
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_req    = 1'b0;
        rd_req    = 1'b0;
        err_clr   = 1'b0;
        wr_data   = '0;
        next_data = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_outputs("reset");
        steps(2, 1'b0, 1'b0, 1'b0);

        // Fill with 0x00..0x0F, then a 17th request while full.
        steps(17, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Drain from full, 17th read underflows.
        steps(17, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // Concurrent traffic at count 5 long enough to wrap both pointers.
        steps(5, 1'b1, 1'b0, 1'b0);
        steps(40, 1'b1, 1'b1, 1'b0);
        steps(11, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        steps(15, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        steps(2, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-burst at count 9, checked before any clock edge.
        steps(9, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        err_clr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_data = 8'hA5;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_sync_ctrl.md
Name: fifo_sync_ctrl

Overview:
Single-clock pointer/flag controller that sequences the team's dual-port FIFO storage RAM (`fifo_mem`) when both of its clocks are tied to one clock.
- Accepts write and read requests from producer and consumer.
- Generates qualified RAM enables and addresses, plus full/empty and almost-full/almost-empty flags, occupancy count, read-data-valid timing and sticky error flags.
- Sits between the requesters and the RAM. The RAM's wr_data/rd_data pass straight through; this block never touches data.

Parameters:
- ADDR_SIZE, 4, RAM address width; DEPTH = 1 << ADDR_SIZE (16 by default).
- ALMOST_FULL_TH, 14, almost_full asserted when count >= this value; legal range 1..DEPTH.
- ALMOST_EMPTY_TH, 2, almost_empty asserted when count <= this value; legal range 0..DEPTH-1.

Ports:
- clk  input  1  single system clock; drives RAM wclk and rclk.
- rst_n  input  1  asynchronous active-low reset; also drives RAM rst_n.
- wr_req  input  1  producer write request, one word per cycle.
- rd_req  input  1  consumer read request, one word per cycle.
- err_clr  input  1  clears overflow/underflow.
- wr_en  output  1  qualified RAM write enable, combinational: wr_req & ~fifo_full.
- rd_en  output  1  qualified RAM read enable, combinational: rd_req & ~fifo_empty.
- wr_addr  output  ADDR_SIZE  RAM write address = wr_ptr[ADDR_SIZE-1:0].
- rd_addr  output  ADDR_SIZE  RAM read address = rd_ptr[ADDR_SIZE-1:0].
- fifo_full  output  1  registered; count == DEPTH.
- fifo_empty  output  1  registered; count == 0.
- almost_full  output  1  registered; count >= ALMOST_FULL_TH.
- almost_empty  output  1  registered; count <= ALMOST_EMPTY_TH.
- fifo_cnt  output  ADDR_SIZE+1  registered occupancy, 0..DEPTH.
- rd_valid  output  1  high the cycle RAM rd_data holds the word from an accepted read.
- overflow  output  1  sticky; set when a write is requested while full.
- underflow  output  1  sticky; set when a read is requested while empty.

Behaviour:
Reset:
- Reset is asynchronous on rst_n low, released synchronously to clk.
- Reset values: wr_ptr = 0, rd_ptr = 0, fifo_cnt = 0, fifo_empty = 1, almost_empty = 1, fifo_full = 0, almost_full = 0 (1 if ALMOST_FULL_TH == 0 is illegal, so 0), rd_valid = 0, overflow = 0, underflow = 0.
- Reset mid-operation discards all contents and pointers immediately.

Pointers:
- wr_ptr and rd_ptr are ADDR_SIZE+1 bits wide and wrap naturally, e.g. 31 -> 0 at the default size.
- wr_ptr increments on wr_en; rd_ptr increments on rd_en.

Accept rules:
- A write is accepted iff wr_en; a read is accepted iff rd_en. Both are decided from the registered flags of the current cycle.
- Full with simultaneous wr_req and rd_req: the read is accepted, the write is rejected and sets overflow. The count goes DEPTH -> DEPTH-1.
- Empty with simultaneous wr_req and rd_req: the write is accepted, the read is rejected and sets underflow. The count goes 0 -> 1. There is no fall-through.
- Neither full nor empty, both accepted: the count is unchanged and both pointers advance.

Count and flags:
- next_cnt = cnt + wr_en - rd_en.
- All four flags are registered from next_cnt, so a flag is valid in the cycle after the causing edge with no extra lag.
- Example: the 16th accepted write gives fifo_full = 1 on the following cycle, so a 17th back-to-back wr_req is rejected.

Read latency:
- rd_valid <= rd_en, i.e. one cycle of latency, matching the RAM's registered rd_data.
- rd_data holds its value while rd_valid is low (RAM property).

Error flags:
- overflow set condition: wr_req & fifo_full. underflow set condition: rd_req & fifo_empty.
- err_clr clears both flags.
- If a set condition and err_clr occur in the same cycle, the set wins.

Pointer invariant:
- wr_ptr - rd_ptr (mod 2^(ADDR_SIZE+1)) == fifo_cnt at all times.
- Full is equivalent to the pointers' MSBs differing and their low bits being equal.

Test Plan:
1. Reset, then idle -> fifo_empty = 1, almost_empty = 1, fifo_cnt = 0, wr_addr = rd_addr = 0, all error flags 0.
2. 16 back-to-back writes of 0x00..0x0F, 17th wr_req held:
   - almost_full rises the cycle after the 14th write.
   - fifo_full = 1 after the 16th write.
   - 17th: wr_en = 0, overflow = 1, fifo_cnt stays 16.
3. 16 back-to-back reads from full:
   - rd_valid is high for 16 cycles, each one cycle after its rd_en.
   - RAM rd_data sequence is 0x00..0x0F.
   - fifo_empty = 1 after the last read; a 17th rd_req sets underflow.
4. Simultaneous wr_req and rd_req:
   - At count 5 for 40 cycles: count stays 5, pointers wrap past 31 -> 0, data order is preserved.
   - At full: count becomes 15, overflow = 1.
   - At empty: count becomes 1, underflow = 1.
5. overflow = 1 with err_clr pulsed alone -> cleared. err_clr concurrent with wr_req while full -> overflow stays 1.
6. Assert rst_n low asynchronously with count at 9 mid-burst -> all outputs return to reset values without waiting for a clk edge. Post-reset, a write/read returns the newly written data.
